param_ram: RTL and testbench
============================

PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter OUT_REG, default 0, adding one read-output register stage when 1.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port cen  input  1  chip enable; request qualifier.
REQ-007 The block SHALL have port wen  input  1  1 = write, 0 = read, when cen=1.
REQ-008 The block SHALL have port s_be  input  DATA_W/8  byte write enables, bit k = byte k.
REQ-009 The block SHALL have port s_addr  input  ADDR_W  word address.
REQ-010 The block SHALL have port s_din  input  DATA_W  write data.
REQ-011 The block SHALL have port clr  input  1  request to zero the whole array.
REQ-012 The block SHALL have port s_dout  output  DATA_W  read data.
REQ-013 The block SHALL have port s_rvalid  output  1  s_dout holds valid read data.
REQ-014 The block SHALL have port busy  output  1  clear sequence in progress.
REQ-015 The block SHALL have port s_err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-016 The clear FSM SHALL have states IDLE and CLEAR, with a clear counter of ADDR_W bits.
REQ-017 In CLEAR, each cycle SHALL write all-zero to word[counter] and increment the counter; after writing DEPTH-1 the FSM SHALL enter IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-018 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-019 In IDLE, clr=1 at an edge SHALL enter CLEAR with counter=0; clr in CLEAR SHALL be ignored (no restart).
REQ-020 In IDLE with cen=1, wen=1 at an edge, for each k with s_be[k]=1, byte k of word[s_addr] SHALL take byte k of s_din; bytes with s_be[k]=0 SHALL be unchanged.
REQ-021 In IDLE with cen=1, wen=0 at edge N, word[s_addr] SHALL appear on s_dout with s_rvalid=1 after edge N (OUT_REG=0) or after edge N+1 (OUT_REG=1), for one cycle per request.
REQ-022 Back-to-back reads SHALL be accepted every cycle (full throughput) in both OUT_REG settings.
REQ-023 Read data SHALL reflect all writes completed at earlier edges; a read immediately after a write to the same address SHALL return the new data.
REQ-024 Whenever s_rvalid=0, s_dout SHALL be all-zero (writes, idle cycles, cen=0, and rejected requests all drive zero).
REQ-025 cen=1 while busy=1 SHALL be rejected: no array write, no s_rvalid, and s_err=1 on the following cycle.
REQ-026 clr=1 and cen=1 on the same edge in IDLE SHALL give the access priority, completing it first; CLEAR SHALL start on that same edge, and the access SHALL not be rejected.
REQ-027 Reads already in the OUT_REG pipeline when CLEAR starts SHALL complete with their pre-clear data.
REQ-028 s_err SHALL be high for exactly one cycle per rejected request and low otherwise.

Reset
REQ-029 rst=1 at an edge SHALL force the FSM to CLEAR with counter=0, s_dout=0, s_rvalid=0, s_err=0, and flush the OUT_REG stage.
REQ-030 rst asserted mid-CLEAR SHALL restart the clear from address 0; array contents SHALL be all-zero once busy first falls after rst is released.
REQ-031 While rst=1, cen and clr SHALL be ignored and s_err SHALL stay 0.

Verification (DATA_W=64, ADDR_W=4, DEPTH=16 unless stated)
REQ-032 Reset pulse -> busy=1 for exactly 16 cycles after release; then reads of addresses 0..15 return 0 with s_rvalid=1.
REQ-033 Write addr 3 = 64'h0123_4567_89AB_CDEF with s_be=8'hFF, then write 64'hFFFF_FFFF_FFFF_FFFF with s_be=8'h0F, then read addr 3 -> 64'h0123_4567_FFFF_FFFF.
REQ-034 Reads of addresses 1, 2, 3 on consecutive cycles, OUT_REG=0 then OUT_REG=1 -> three consecutive s_rvalid pulses, with 1- and 2-cycle latency respectively and correct data in order.
REQ-035 clr pulse, then cen=1 read on the next cycle -> s_err=1 for one cycle, s_rvalid=0, s_dout=0; after busy falls, previously written addresses read 0.
REQ-036 rst asserted at clear cycle 7 -> busy stays 1 for 16 further cycles after release; then all words read 0.
REQ-037 cen=0 with any wen/s_be/s_addr values -> array unchanged, s_rvalid=0, s_dout=0.

Source files
------------

// File: rtl/param_ram_if.sv
// Request/response bundle for param_ram: access request, clear request,
// read return and status.
interface param_ram_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic                  cen;
  logic                  wen;
  logic [DATA_W/8-1:0]   s_be;
  logic [ADDR_W-1:0]     s_addr;
  logic [DATA_W-1:0]     s_din;
  logic                  clr;
  logic [DATA_W-1:0]     s_dout;
  logic                  s_rvalid;
  logic                  busy;
  logic                  s_err;

  modport master (
    output cen, wen, s_be, s_addr, s_din, clr,
    input  s_dout, s_rvalid, busy, s_err
  );

  modport slave (
    input  cen, wen, s_be, s_addr, s_din, clr,
    output s_dout, s_rvalid, busy, s_err
  );
endinterface

// File: rtl/param_ram.sv
// Single-port byte-writable RAM with a sequential whole-array clear and an
// optional read-output register stage.
module param_ram #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  param_ram_if.slave   bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc, wr_en, rd_en;
  logic                rv0;
  logic [DATA_W-1:0]   d0;
  logic                err_q;

  // Accesses are only serviced in IDLE; during rst everything is ignored.
  assign acc   = bus.cen && (state == IDLE) && !rst;
  assign wr_en = acc && bus.wen;
  assign rd_en = acc && !bus.wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        for (int unsigned k = 0; k < BE_W; k++) begin
          if (bus.s_be[k]) mem[bus.s_addr][8*k +: 8] <= bus.s_din[8*k +: 8];
        end
      end
    end
  end

  // Read data register is zeroed on any non-read cycle so s_dout is 0 whenever invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0   <= 1'b0;
      d0    <= '0;
      err_q <= 1'b0;
    end else begin
      rv0   <= rd_en;
      d0    <= rd_en ? mem[bus.s_addr] : '0;
      err_q <= bus.cen && (state == CLEAR);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              rv1;
      logic [DATA_W-1:0] d1;
      always_ff @(posedge clk) begin
        if (rst) begin
          rv1 <= 1'b0;
          d1  <= '0;
        end else begin
          rv1 <= rv0;
          d1  <= d0;
        end
      end
      assign bus.s_rvalid = rv1;
      assign bus.s_dout   = d1;
    end else begin : g_no_out_reg
      assign bus.s_rvalid = rv0;
      assign bus.s_dout   = d0;
    end
  endgenerate

  assign bus.busy  = (state == CLEAR);
  assign bus.s_err = err_q;
endmodule

// File: tb/tb_param_ram.sv
// Self-checking bench for param_ram: two instances (OUT_REG=0 and 1) share
// one stimulus stream and are compared against a behavioural array model.
module tb_param_ram;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst = 1'b1, i_cen = 1'b0, i_wen = 1'b0, i_clr = 1'b0;
  logic [7:0]  i_be = '0;
  logic [3:0]  i_addr = '0;
  logic [63:0] i_din = '0;

  param_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  param_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.cen = i_cen;  assign bus0.wen = i_wen;   assign bus0.s_be = i_be;
  assign bus0.s_addr = i_addr; assign bus0.s_din = i_din; assign bus0.clr = i_clr;
  assign bus1.cen = i_cen;  assign bus1.wen = i_wen;   assign bus1.s_be = i_be;
  assign bus1.s_addr = i_addr; assign bus1.s_din = i_din; assign bus1.clr = i_clr;

  param_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (.clk(clk), .rst(i_rst), .bus(bus0));
  param_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (.clk(clk), .rst(i_rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Behavioural model: array contents, remaining clear words, expected outputs.
  logic [63:0] m_mem [DEPTH];
  int          clr_left = DEPTH;
  logic        e_err = 1'b0, e_rv0 = 1'b0, e_rv1 = 1'b0;
  logic [63:0] e_d0 = '0, e_d1 = '0;

  task automatic model_edge();
    logic        p_rv;
    logic [63:0] p_d;
    p_rv = e_rv0;
    p_d  = e_d0;
    if (i_rst) begin
      clr_left = DEPTH;
      e_err = 1'b0; e_rv0 = 1'b0; e_d0 = '0; e_rv1 = 1'b0; e_d1 = '0;
    end else begin
      e_rv1 = p_rv; e_d1 = p_d;
      e_rv0 = 1'b0; e_d0 = '0; e_err = 1'b0;
      if (clr_left > 0) begin
        m_mem[DEPTH - clr_left] = '0;
        clr_left--;
        e_err = i_cen;
      end else begin
        if (i_cen && i_wen) begin
          for (int k = 0; k < 8; k++)
            if (i_be[k]) m_mem[i_addr][8*k +: 8] = i_din[8*k +: 8];
        end else if (i_cen) begin
          e_rv0 = 1'b1;
          e_d0  = m_mem[i_addr];
        end
        if (i_clr) clr_left = DEPTH;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic cen, input logic wen, input logic [7:0] be,
                       input logic [3:0] addr, input logic [63:0] din, input logic clr);
    i_cen = cen; i_wen = wen; i_be = be; i_addr = addr; i_din = din; i_clr = clr;
  endtask

  task automatic test_reset();
    int n;
    step(); step();
    checks++;
    if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy got %b/%b want 1/1", bus0.busy, bus1.busy);
    end
    checks++;
    if ({bus0.s_rvalid, bus1.s_rvalid, bus0.s_err, bus1.s_err} !== 4'b0 ||
        bus0.s_dout !== '0 || bus1.s_dout !== '0) begin
      errors++; $display("FAIL reset_outputs got rv %b%b err %b%b dout %h %h want zeros",
                         bus0.s_rvalid, bus1.s_rvalid, bus0.s_err, bus1.s_err, bus0.s_dout, bus1.s_dout);
    end
    i_rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (bus0.busy && n < 40);
    checks++;
    if (n != 16 || bus1.busy !== 1'b0) begin
      errors++; $display("FAIL reset_clear_len got %0d cycles (busy1=%b) want 16", n, bus1.busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, 8'h00, 4'(a), '0, 0);
      step();
      checks++;
      if (bus0.s_rvalid !== 1'b1 || bus0.s_dout !== 64'h0 || bus1.s_rvalid !== (a > 0)) begin
        errors++; $display("FAIL reset_read addr %0d got rv %b/%b dout %h want rv 1/%b dout 0",
                           a, bus0.s_rvalid, bus1.s_rvalid, bus0.s_dout, a > 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_byte_enable();
    drive(1, 1, 8'hFF, 4'd3, 64'h0123_4567_89AB_CDEF, 0); step();
    drive(1, 1, 8'h0F, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0); step();
    drive(1, 0, 8'h00, 4'd3, 64'h0, 0); step();
    checks++;
    if (bus0.s_rvalid !== 1'b1 || bus0.s_dout !== 64'h0123_4567_FFFF_FFFF) begin
      errors++; $display("FAIL byte_enable_r0 got rv %b dout %h want 1 01234567ffffffff",
                         bus0.s_rvalid, bus0.s_dout);
    end
    drive(0, 0, 0, 0, 0, 0); step();
    checks++;
    if (bus1.s_rvalid !== 1'b1 || bus1.s_dout !== 64'h0123_4567_FFFF_FFFF || bus0.s_rvalid !== 1'b0) begin
      errors++; $display("FAIL byte_enable_r1 got rv %b dout %h (rv0 %b) want 1 01234567ffffffff (0)",
                         bus1.s_rvalid, bus1.s_dout, bus0.s_rvalid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [4];
    logic [63:0] w0 [5], w1 [5];
    logic        r0 [5], r1 [5];
    for (int a = 1; a <= 3; a++) begin
      v[a] = {$urandom, $urandom};
      drive(1, 1, 8'hFF, 4'(a), v[a], 0); step();
    end
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1, 0, 0, 4'(c + 1), 0, 0); else drive(0, 0, 0, 0, 0, 0);
      step();
      r0[c] = bus0.s_rvalid; w0[c] = bus0.s_dout; r1[c] = bus1.s_rvalid; w1[c] = bus1.s_dout;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (r0[c] !== (c < 3) || w0[c] !== ((c < 3) ? v[c + 1] : 64'h0)) begin
        errors++; $display("FAIL b2b_r0 cycle %0d got rv %b dout %h want rv %b dout %h",
                           c, r0[c], w0[c], c < 3, (c < 3) ? v[c + 1] : 64'h0);
      end
      checks++;
      if (r1[c] !== (c >= 1 && c <= 3) || w1[c] !== ((c >= 1 && c <= 3) ? v[c] : 64'h0)) begin
        errors++; $display("FAIL b2b_r1 cycle %0d got rv %b dout %h want rv %b dout %h",
                           c, r1[c], w1[c], c >= 1 && c <= 3, (c >= 1 && c <= 3) ? v[c] : 64'h0);
      end
    end
  endtask

  task automatic test_clear_reject();
    int n;
    drive(1, 1, 8'hFF, 4'd5, 64'hDEAD_BEEF_CAFE_F00D, 1); step();
    checks++;
    if (bus0.busy !== 1'b1 || bus0.s_err !== 1'b0) begin
      errors++; $display("FAIL clr_priority got busy %b err %b want 1 0", bus0.busy, bus0.s_err);
    end
    drive(1, 0, 0, 4'd5, 0, 0); step();
    checks++;
    if (bus0.s_err !== 1'b1 || bus1.s_err !== 1'b1 || bus0.s_rvalid !== 1'b0 || bus0.s_dout !== 64'h0) begin
      errors++; $display("FAIL reject got err %b/%b rv %b dout %h want 1/1 0 0",
                         bus0.s_err, bus1.s_err, bus0.s_rvalid, bus0.s_dout);
    end
    drive(0, 0, 0, 0, 0, 1); step();
    checks++;
    if (bus0.s_err !== 1'b0 || bus1.s_rvalid !== 1'b0 || bus1.s_dout !== 64'h0) begin
      errors++; $display("FAIL reject_pulse got err %b rv1 %b dout1 %h want 0 0 0",
                         bus0.s_err, bus1.s_rvalid, bus1.s_dout);
    end
    drive(0, 0, 0, 0, 0, 0);
    n = 2;
    while (bus0.busy && n < 40) begin step(); n++; end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL clr_len got %0d cycles want 16 (clr mid-clear must not restart)", n);
    end
    drive(1, 0, 0, 4'd5, 0, 0); step();
    checks++;
    if (bus0.s_rvalid !== 1'b1 || bus0.s_dout !== 64'h0) begin
      errors++; $display("FAIL clr_readback got rv %b dout %h want 1 0", bus0.s_rvalid, bus0.s_dout);
    end
    drive(0, 0, 0, 0, 0, 0); step();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 1, 8'hFF, 4'(a), {$urandom, $urandom} | 64'h1, 0); step();
    end
    drive(0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (7) step();
    i_rst = 1'b1; drive(1, 1, 8'hFF, 4'd9, 64'h5555, 1); step();
    checks++;
    if (bus0.s_err !== 1'b0 || bus0.busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid got err %b busy %b want 0 1", bus0.s_err, bus0.busy);
    end
    i_rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    n = 0;
    do begin step(); n++; end while (bus0.busy && n < 40);
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL rst_mid_len got %0d cycles want 16", n);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, 0, 4'(a), 0, 0); step();
      checks++;
      if (bus0.s_rvalid !== 1'b1 || bus0.s_dout !== 64'h0) begin
        errors++; $display("FAIL rst_mid_read addr %0d got rv %b dout %h want 1 0", a, bus0.s_rvalid, bus0.s_dout);
      end
    end
    drive(0, 0, 0, 0, 0, 0); step();
  endtask

  task automatic test_cen_low();
    for (int c = 0; c < 12; c++) begin
      drive(0, 1'($urandom), 8'($urandom), 4'($urandom), {$urandom, $urandom}, 0);
      step();
      if (c < 2) continue;
      checks++;
      if ({bus0.s_rvalid, bus1.s_rvalid, bus0.s_err} !== 3'b0 || bus0.s_dout !== '0 || bus1.s_dout !== '0) begin
        errors++; $display("FAIL cen_low cycle %0d got rv %b%b err %b dout %h %h want zeros",
                           c, bus0.s_rvalid, bus1.s_rvalid, bus0.s_err, bus0.s_dout, bus1.s_dout);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      i_rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 9) < 7), 1'($urandom), 8'($urandom), 4'($urandom),
            {$urandom, $urandom}, ($urandom_range(0, 49) == 0));
      step();
      checks++;
      if (bus0.busy !== (clr_left > 0) || bus0.s_err !== e_err || bus0.s_rvalid !== e_rv0 ||
          bus0.s_dout !== e_d0 || bus1.s_err !== e_err || bus1.s_rvalid !== e_rv1 || bus1.s_dout !== e_d1) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random cycle %0d got busy %b err %b rv %b/%b dout %h/%h want %b %b %b/%b %h/%h",
                   c, bus0.busy, bus0.s_err, bus0.s_rvalid, bus1.s_rvalid, bus0.s_dout, bus1.s_dout,
                   clr_left > 0, e_err, e_rv0, e_rv1, e_d0, e_d1);
      end
    end
    i_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_final_readback();
    int n;
    n = 0;
    while (bus0.busy && n < 40) begin step(); n++; end
    checks++;
    if (bus0.busy !== 1'b0) begin
      errors++; $display("FAIL final_wait got busy %b want 0 within 40 cycles", bus0.busy);
    end
    for (int a = 0; a <= DEPTH; a++) begin
      if (a < DEPTH) drive(1, 0, 0, 4'(a), 0, 0); else drive(0, 0, 0, 0, 0, 0);
      step();
      if (a < DEPTH) begin
        checks++;
        if (bus0.s_rvalid !== 1'b1 || bus0.s_dout !== m_mem[a]) begin
          errors++; $display("FAIL readback0 addr %0d got rv %b dout %h want 1 %h", a, bus0.s_rvalid, bus0.s_dout, m_mem[a]);
        end
      end
      if (a > 0) begin
        checks++;
        if (bus1.s_rvalid !== 1'b1 || bus1.s_dout !== m_mem[a - 1]) begin
          errors++; $display("FAIL readback1 addr %0d got rv %b dout %h want 1 %h", a - 1, bus1.s_rvalid, bus1.s_dout, m_mem[a - 1]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) m_mem[a] = {$urandom, $urandom};
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear_reject();
    test_reset_mid_clear();
    test_cen_low();
    test_random();
    test_final_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
